// File: rtl/fetch_mem_responder.sv
// Instruction-fetch memory responder: one outstanding request, fixed latency.
// Ports: clk/reset (async active-low); req_valid/req_ready/req_addr request side;
// rsp_valid/rsp_ready/rsp_data/rsp_err response side; load_en/load_idx/load_data
// word loader. Optional macro FETCH_MEM_ERR_CHECK_EN enables address checking.
module fetch_mem_responder #(
    parameter int AWIDTH      = 32,
    parameter int DWIDTH      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter logic [AWIDTH-1:0] BASE_ADDR = AWIDTH'(32'h0100_0000)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [AWIDTH-1:0]              req_addr,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DWIDTH-1:0]              rsp_data,
    output logic                           rsp_err,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_idx,
    input  logic [DWIDTH-1:0]              load_data
);

    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DWIDTH-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic              rdy_q, rdy_d;

    logic [DWIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [AWIDTH-1:0] off_w;
    logic [AWIDTH-1:0] word_w;
    logic [IW-1:0]     idx_w;
    logic              err_w;
    logic              accept_w;

    assign off_w  = req_addr - BASE_ADDR;
    assign word_w = off_w >> 2;

`ifdef FETCH_MEM_ERR_CHECK_EN
    assign err_w = (req_addr[1:0] != 2'b00) ||
                   (req_addr < BASE_ADDR) ||
                   (word_w >= AWIDTH'(DEPTH_WORDS));
    assign idx_w = IW'(word_w);
`else
    assign err_w = 1'b0;
    assign idx_w = IW'(word_w % AWIDTH'(DEPTH_WORDS));
`endif

    // req_ready is registered so it rises one cycle after entering IDLE,
    // both after reset release and after a response handshake.
    assign req_ready = rdy_q;
    assign accept_w  = req_valid && rdy_q;

    assign rsp_valid = (state_q == RESP);
    assign rsp_data  = rsp_valid ? data_q : '0;
    assign rsp_err   = rsp_valid && err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;
        rdy_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                rdy_d = !accept_w;
                if (accept_w) begin
                    // Reads the pre-write word when a load hits the same index.
                    data_d  = err_w ? '0 : mem_q[idx_w];
                    err_d   = err_w;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    data_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
        end
    end

    // Memory contents survive reset, so this array has no reset branch.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_q[load_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_fetch_mem_responder.sv
// Directed bench for fetch_mem_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=1 instance for back-to-back throughput.
module tb_fetch_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, load_en;
    logic [31:0] req_addr, rsp_data, load_data;
    logic [9:0]  load_idx;

    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
    logic        b_rsp_err, b_load_en;
    logic [31:0] b_req_addr, b_rsp_data, b_load_data;
    logic [9:0]  b_load_idx;

    int total = 0;
    int bad   = 0;

    logic [31:0] bw [3];

    always #5 clk = ~clk;

    fetch_mem_responder u0 (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .load_en  (load_en),
        .load_idx (load_idx),
        .load_data(load_data)
    );

    fetch_mem_responder #(.LATENCY(1)) u1 (
        .clk      (clk),
        .reset    (reset),
        .req_valid(b_req_valid),
        .req_ready(b_req_ready),
        .req_addr (b_req_addr),
        .rsp_valid(b_rsp_valid),
        .rsp_ready(b_rsp_ready),
        .rsp_data (b_rsp_data),
        .rsp_err  (b_rsp_err),
        .load_en  (b_load_en),
        .load_idx (b_load_idx),
        .load_data(b_load_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Full LATENCY=2 fetch followed by an immediate handshake.
    task automatic fetch(input string tag, input logic [31:0] a,
                         input logic [31:0] d, input logic e);
        req_valid = 1'b1;
        req_addr  = a;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk({tag, "_v"}, 64'(rsp_valid), 64'd1);
        chk({tag, "_d"}, 64'(rsp_data), 64'(d));
        chk({tag, "_e"}, 64'(rsp_err), 64'(e));
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
    endtask

    initial begin
        bw[0] = 32'hB000_0000;
        bw[1] = 32'hB111_1111;
        bw[2] = 32'hB222_2222;

        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        load_en   = 1'b1;
        load_idx  = 10'd0;
        load_data = 32'h0050_0093;
        b_req_valid = 1'b0;
        b_req_addr  = '0;
        b_rsp_ready = 1'b0;
        b_load_en   = 1'b1;
        b_load_idx  = 10'd0;
        b_load_data = bw[0];

        step();
        load_idx    = 10'd1;
        load_data   = 32'h1111_1111;
        b_load_idx  = 10'd1;
        b_load_data = bw[1];
        step();
        load_en     = 1'b0;
        b_load_idx  = 10'd2;
        b_load_data = bw[2];
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_data", 64'(rsp_data), 64'd0);
        chk("rst_err", 64'(rsp_err), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_b_ready", 64'(b_req_ready), 64'd0);
        step();
        b_load_en = 1'b0;
        reset     = 1'b1;
        chk("rdy_pre_edge", 64'(req_ready), 64'd0);
        step();
        chk("rdy_post_edge", 64'(req_ready), 64'd1);

        // Basic fetch with exact latency check.
        req_valid = 1'b1;
        req_addr  = 32'h0100_0000;
        step();
        req_valid = 1'b0;
        chk("lat_e0_v", 64'(rsp_valid), 64'd0);
        chk("lat_e0_rdy", 64'(req_ready), 64'd0);
        step();
        chk("lat_e1_v", 64'(rsp_valid), 64'd0);
        step();
        chk("lat_e2_v", 64'(rsp_valid), 64'd1);
        chk("lat_e2_d", 64'(rsp_data), 64'h0050_0093);
        chk("lat_e2_e", 64'(rsp_err), 64'd0);

        // Backpressure; a load of word 0 mid-hold must not disturb the response.
        for (int i = 0; i < 5; i++) begin
            load_en   = (i == 2);
            load_idx  = 10'd0;
            load_data = 32'hDEAD_BEEF;
            step();
            chk("hold_v", 64'(rsp_valid), 64'd1);
            chk("hold_d", 64'(rsp_data), 64'h0050_0093);
            chk("hold_rdy", 64'(req_ready), 64'd0);
        end
        load_en   = 1'b0;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("hs_v", 64'(rsp_valid), 64'd0);
        chk("hs_d", 64'(rsp_data), 64'd0);
        chk("hs_rdy", 64'(req_ready), 64'd0);
        step();
        chk("hs_rdy_next", 64'(req_ready), 64'd1);

        // Load colliding with accept returns the old word.
        req_valid = 1'b1;
        req_addr  = 32'h0100_0004;
        load_en   = 1'b1;
        load_idx  = 10'd1;
        load_data = 32'hAAAA_AAAA;
        step();
        req_valid = 1'b0;
        load_en   = 1'b0;
        step();
        step();
        chk("coll_old", 64'(rsp_data), 64'h1111_1111);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        step();
        fetch("coll_new", 32'h0100_0004, 32'hAAAA_AAAA, 1'b0);

        // Reset while waiting drops the request.
        req_valid = 1'b1;
        req_addr  = 32'h0100_0004;
        step();
        req_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk("rwait_v", 64'(rsp_valid), 64'd0);
        chk("rwait_rdy", 64'(req_ready), 64'd0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rwait_norsp", 64'(rsp_valid), 64'd0);
        end
        req_valid = 1'b1;
        req_addr  = 32'h0100_0004;
        step();
        req_valid = 1'b0;
        step();
        step();
        chk("mem_keep", 64'(rsp_data), 64'hAAAA_AAAA);

        // Reset while the response is presented clears it at once.
        #1 reset = 1'b0;
        #1;
        chk("rresp_v", 64'(rsp_valid), 64'd0);
        chk("rresp_d", 64'(rsp_data), 64'd0);
        step();
        reset = 1'b1;
        step();

`ifdef FETCH_MEM_ERR_CHECK_EN
        fetch("err_misal", 32'h0100_0002, 32'h0, 1'b1);
        fetch("err_below", 32'h0000_0000, 32'h0, 1'b1);
        fetch("err_ok", 32'h0100_0004, 32'hAAAA_AAAA, 1'b0);
`else
        fetch("wrap", 32'h0100_1000, 32'hDEAD_BEEF, 1'b0);
        fetch("lowbits", 32'h0100_0006, 32'hAAAA_AAAA, 1'b0);
`endif

        // LATENCY=1 back-to-back: one response every 3 cycles, in order.
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1;
        b_req_addr  = 32'h0100_0000;
        for (int k = 0; k < 3; k++) begin
            chk("b2b_rdy", 64'(b_req_ready), 64'd1);
            step();
            b_req_addr = 32'h0100_0000 + 32'(4 * (k + 1));
            chk("b2b_v", 64'(b_rsp_valid), 64'd1);
            chk("b2b_d", 64'(b_rsp_data), 64'(bw[k]));
            chk("b2b_rdy0", 64'(b_req_ready), 64'd0);
            step();
            chk("b2b_gap_v", 64'(b_rsp_valid), 64'd0);
            chk("b2b_gap_rdy", 64'(b_req_ready), 64'd0);
            step();
        end
        b_req_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_mem_responder.md
FETCH_MEM_RESPONDER -- requirements
Module: fetch_mem_responder

Interface
REQ-001 SHALL have parameter AWIDTH, default 32: address width.
REQ-002 SHALL have parameter DWIDTH, default 32: data width.
REQ-003 SHALL have parameter DEPTH_WORDS, default 1024: memory depth in DWIDTH words.
REQ-004 SHALL have parameter LATENCY, default 2, legal 1..15: cycles from request accept to rsp_valid.
REQ-005 SHALL have parameter BASE_ADDR, default 32'h0100_0000: byte address of word 0.
REQ-006 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port req_valid  input  1  fetch request present.
REQ-009 SHALL have port req_ready  output  1  responder can accept a request.
REQ-010 SHALL have port req_addr  input  AWIDTH  byte address of fetch.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-013 SHALL have port rsp_data  output  DWIDTH  fetched word.
REQ-014 SHALL have port rsp_err  output  1  access error flag, qualified by rsp_valid.
REQ-015 SHALL have port load_en  input  1  bench/loader word write strobe.
REQ-016 SHALL have port load_idx  input  $clog2(DEPTH_WORDS)  word index for load.
REQ-017 SHALL have port load_data  input  DWIDTH  word to write.

Function
REQ-018 SHALL implement states IDLE, WAIT, RESP; one outstanding request maximum.
REQ-019 SHALL drive req_ready=1 only in IDLE; accept when req_valid && req_ready.
REQ-020 SHALL on accept capture word index (req_addr-BASE_ADDR)>>2 and the addressed word, load LATENCY-1 into countdown, go to WAIT (LATENCY=1: straight to RESP).
REQ-021 SHALL in WAIT decrement countdown each cycle; at zero go to RESP.
REQ-022 SHALL assert rsp_valid exactly LATENCY cycles after the accept edge, holding rsp_data/rsp_err stable until rsp_valid && rsp_ready.
REQ-023 SHALL on response handshake return to IDLE; a new request SHALL NOT be accepted in that same cycle (req_ready rises one cycle later).
REQ-024 SHALL write load_data to load_idx on any cycle load_en=1, independent of state.
REQ-025 SHALL, when load_en targets the word being accepted in the same cycle, return the old (pre-write) word.
REQ-026 SHALL NOT alter an already captured response due to later loads.
REQ-027 SHALL drive rsp_data=0 whenever rsp_valid=0.

Reset
REQ-028 SHALL on reset=0 immediately force state IDLE, countdown 0, rsp_valid=0, rsp_data=0, rsp_err=0, req_ready=0.
REQ-029 SHALL drive req_ready=1 from the first rising clk edge after reset deasserts.
REQ-030 SHALL drop any in-flight request on reset mid-operation; no response SHALL follow.
REQ-031 SHALL NOT clear memory contents on reset.

Configuration
REQ-032 SHALL, with macro FETCH_MEM_ERR_CHECK_EN defined, flag rsp_err=1 and rsp_data=0 when req_addr[1:0]!=0, req_addr<BASE_ADDR, or word index>=DEPTH_WORDS; latency unchanged.
REQ-033 SHALL, without FETCH_MEM_ERR_CHECK_EN, tie rsp_err=0, ignore req_addr[1:0], and wrap the word index modulo DEPTH_WORDS.

Verification
REQ-034 SHALL cover: load idx0=32'h0050_0093, reset 2 cycles, request 32'h0100_0000 -> rsp_valid exactly 2 cycles after accept, rsp_data=32'h0050_0093, rsp_err=0.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout; after handshake req_ready=1 one cycle later.
REQ-036 SHALL cover: load idx1=32'hAAAA_AAAA in same cycle as accept of 32'h0100_0004 (old 32'h1111_1111) -> rsp_data=32'h1111_1111; next fetch returns 32'hAAAA_AAAA.
REQ-037 SHALL cover: reset asserted in WAIT -> rsp_valid=0 immediately, no response after release, memory contents intact.
REQ-038 SHALL cover: with FETCH_MEM_ERR_CHECK_EN, address 32'h0100_0002 and 32'h0000_0000 -> rsp_err=1, rsp_data=0; without, 32'h0100_1000 returns idx0 word.
REQ-039 SHALL cover: LATENCY=1 build, back-to-back requests with rsp_ready=1 -> one response per 3 cycles, addresses in order.
